// File: rtl/root_pkg.sv
//==============================================================================
// Module      : root_pkg
// Description : Shared Q10.10 constants and FSM state encoding for the
//               power and root datapath blocks.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package root_pkg;

    localparam int Q_FRAC = 10;
    localparam int Q_W    = 20;

    localparam logic [Q_W-1:0] Q_ONE = 20'h00400;
    localparam logic [Q_W-1:0] Q_MAX = 20'hFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fixed_power_if.sv
//==============================================================================
// Module      : fixed_power_if
// Description : Start/result handshake bundle of the fixed-point power unit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface fixed_power_if #(
    parameter int DATA_W = root_pkg::Q_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data_1;
    logic [2:0]        in_data_2;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_sat;
    logic              busy;

    modport master (
        output in_valid, in_data_1, in_data_2,
        input  out_valid, out_data, out_sat, busy
    );

    modport slave (
        input  in_valid, in_data_1, in_data_2,
        output out_valid, out_data, out_sat, busy
    );
endinterface

`default_nettype wire

// File: rtl/fixed_mul_sat.sv
//==============================================================================
// Module      : fixed_mul_sat
// Description : Combinational unsigned fixed-point multiply, truncating the
//               fractional tail and saturating to all-ones on overflow.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fixed_mul_sat
    import root_pkg::*;
#(
    parameter int FRAC_BITS = Q_FRAC,
    parameter int DATA_W    = Q_W
) (
    input  wire logic [DATA_W-1:0] a,
    input  wire logic [DATA_W-1:0] b,
    output logic      [DATA_W-1:0] q,
    output logic                   ovf
);

    logic [2*DATA_W-1:0] w_prod;
    logic [2*DATA_W-1:0] w_shift;

    assign w_prod  = a * b;
    assign w_shift = w_prod >> FRAC_BITS;

    // Any integer bits beyond the result width mean the value is unrepresentable
    assign ovf = |w_shift[2*DATA_W-1:DATA_W];
    assign q   = ovf ? '1 : w_shift[DATA_W-1:0];

endmodule

`default_nettype wire

// File: rtl/fixed_power.sv
//==============================================================================
// Module      : fixed_power
// Description : Iterative Q10.10 power unit, base^n for n in 0..7, one shared
//               multiply per cycle, saturating result.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fixed_power
    import root_pkg::*;
#(
    parameter int FRAC_BITS = Q_FRAC,
    parameter int DATA_W    = Q_W
) (
    input  wire logic        clk,
    input  wire logic        rst,
    fixed_power_if.slave     bus
);

    localparam logic [DATA_W-1:0] C_ONE = DATA_W'(1) << FRAC_BITS;

    state_t            r_state;
    logic [DATA_W-1:0] r_base;
    logic [DATA_W-1:0] r_acc;
    logic [2:0]        r_cnt;
    logic              r_sat;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_sat;

    logic [DATA_W-1:0] w_prod_q;
    logic              w_prod_ovf;

    fixed_mul_sat #(
        .FRAC_BITS (FRAC_BITS),
        .DATA_W    (DATA_W)
    ) u_mul (
        .a   (r_acc),
        .b   (r_base),
        .q   (w_prod_q),
        .ovf (w_prod_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_acc       <= '0;
            r_cnt       <= 3'd0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_base  <= bus.in_data_1;
                        r_cnt   <= bus.in_data_2;
                        r_acc   <= C_ONE;
                        r_sat   <= 1'b0;
                        r_state <= (bus.in_data_2 == 3'd0) ? DONE : MUL;
                    end
                end
                MUL: begin
                    r_acc <= w_prod_q;
                    // Saturation is sticky for the remainder of the operation
                    r_sat <= r_sat | w_prod_ovf;
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_out_data  <= r_acc;
                    r_out_sat   <= r_sat;
                    r_out_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;
    assign bus.busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fixed_power.sv
//==============================================================================
// Module      : tb_fixed_power
// Description : Self-checking bench for fixed_power: vector table, random
//               operands against an arithmetic model, and control sequences.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fixed_power;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    fixed_power_if bus ();

    fixed_power dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] base;
        logic [2:0]  n;
        logic [19:0] exp_data;
        logic        exp_sat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: repeated real-valued multiply, truncated to 2^-10 and clamped
    function automatic void model(input logic [19:0] base, input logic [2:0] n,
                                  output logic [19:0] data, output logic sat);
        longint acc;
        longint q;
        acc = 1024;
        sat = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            q = (acc * longint'(base)) / 1024;
            if (q > 64'hFFFFF) begin
                acc = 64'hFFFFF;
                sat = 1'b1;
            end else begin
                acc = q;
            end
        end
        data = acc[19:0];
    endfunction

    // Starts an operation at the next negedge and checks latency and result.
    // With junk=1, random in_valid pulses and operand noise are driven while busy.
    task automatic run_op(input string name, input logic [19:0] base, input logic [2:0] n,
                          input logic [19:0] exp_data, input logic exp_sat, input bit junk);
        bit early;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data_1 = base;
        bus.in_data_2 = n;
        early = 1'b0;
        for (int k = 0; k <= int'(n); k++) begin
            @(negedge clk);
            bus.in_valid  = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.in_data_1 = 20'($urandom);
            bus.in_data_2 = 3'($urandom);
            if (bus.out_valid || !bus.busy) early = 1'b1;
        end
        check({name, " early_valid_or_idle"}, 64'(early), 64'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({name, " out_valid"}, 64'(bus.out_valid), 64'd1);
        check({name, " busy_in_valid_cycle"}, 64'(bus.busy), 64'd0);
        check({name, " out_data"}, 64'(bus.out_data), 64'(exp_data));
        check({name, " out_sat"}, 64'(bus.out_sat), 64'(exp_sat));
        @(negedge clk);
        check({name, " out_valid_falls"}, 64'(bus.out_valid), 64'd0);
        check({name, " out_data_holds"}, 64'(bus.out_data), 64'(exp_data));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [10];
        logic [19:0] m_data;
        logic        m_sat;
        int          cyc;
        bit          seen;

        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{20'h00600, 3'd2, 20'h00900, 1'b0};
        vecs[1] = '{20'h00000, 3'd0, 20'h00400, 1'b0};
        vecs[2] = '{20'h00800, 3'd7, 20'h20000, 1'b0};
        vecs[3] = '{20'h07C00, 3'd3, 20'hFFFFF, 1'b1};
        vecs[4] = '{20'h00001, 3'd2, 20'h00000, 1'b0};
        vecs[5] = '{20'h00000, 3'd3, 20'h00000, 1'b0};
        vecs[6] = '{20'hFFFFF, 3'd0, 20'h00400, 1'b0};
        vecs[7] = '{20'h00400, 3'd7, 20'h00400, 1'b0};
        vecs[8] = '{20'h00200, 3'd1, 20'h00200, 1'b0};
        vecs[9] = '{20'hFFFFF, 3'd1, 20'hFFFFF, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data_1 = '0;
        bus.in_data_2 = '0;
        repeat (3) @(negedge clk);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset out_data", 64'(bus.out_data), 64'd0);
        check("reset out_sat", 64'(bus.out_sat), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].base, vecs[i].n,
                   vecs[i].exp_data, vecs[i].exp_sat, (i % 2) == 1);
        end

        for (int i = 0; i < 30; i++) begin
            logic [19:0] b;
            logic [2:0]  n;
            b = (i % 3 == 0) ? 20'($urandom) : 20'($urandom_range(0, 20'h00C00));
            n = 3'($urandom);
            model(b, n, m_data, m_sat);
            run_op($sformatf("rand%0d", i), b, n, m_data, m_sat, 1'b1);
        end

        // Back-to-back: second start in the out_valid cycle of the first
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data_1 = 20'h00600;
        bus.in_data_2 = 3'd2;
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        check("b2b first out_valid", 64'(bus.out_valid), 64'd1);
        check("b2b first out_data", 64'(bus.out_data), 64'h00900);
        bus.in_valid  = 1'b1;
        bus.in_data_1 = 20'h00800;
        bus.in_data_2 = 3'd3;
        seen = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.out_valid) seen = 1'b1;
        end
        check("b2b second early_valid", 64'(seen), 64'd0);
        @(negedge clk);
        check("b2b second out_valid", 64'(bus.out_valid), 64'd1);
        check("b2b second out_data", 64'(bus.out_data), 64'h02000);
        check("b2b second out_sat", 64'(bus.out_sat), 64'd0);

        // Reset during MUL of an n=5 operation aborts it
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data_1 = 20'h00600;
        bus.in_data_2 = 3'd5;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("abort busy before rst", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort out_valid", 64'(bus.out_valid), 64'd0);
        check("abort out_data", 64'(bus.out_data), 64'd0);
        check("abort out_sat", 64'(bus.out_sat), 64'd0);
        check("abort busy", 64'(bus.busy), 64'd0);
        seen = 1'b0;
        for (cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) seen = 1'b1;
        end
        check("abort no late result", 64'(seen), 64'd0);
        run_op("after_abort", 20'h00600, 3'd2, 20'h00900, 1'b0, 1'b0);

        // Reset wins over a simultaneous start
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data_1 = 20'h00800;
        bus.in_data_2 = 3'd1;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_vs_start busy", 64'(bus.busy), 64'd0);
        seen = 1'b0;
        for (cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("rst_vs_start no result", 64'(seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
